// File: rtl/led_ctrl_pkg.sv
// Purpose : shared types, sizes and helpers for the LED arbiter slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package led_ctrl_pkg;

   localparam int N_REQ = 4;   // number of pattern requesters
   localparam int LED_W = 4;   // width of led_out and of each pattern

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Pull requester idx's pattern out of the packed pattern bus.
   function automatic logic [LED_W-1:0] pat_slice(
      input logic [N_REQ*LED_W-1:0] pats,
      input logic [1:0]             idx
   );
      pat_slice = pats[int'(idx)*LED_W +: LED_W];
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Purpose : combinational 4-way round-robin picker, search starts at last+1.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; caller decides whether to act on the pick.
//
// Ports:
//   req    - request levels, bit i = requester i
//   last   - index of the previous winner
//   winner - chosen index (meaningful only when valid)
//   valid  - at least one request present
module rr_pick4
   import led_ctrl_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       last,
   output logic [1:0]       winner,
   output logic             valid
);

   logic [1:0] idx;

   // Walk from the farthest offset (4 = last itself) down to the nearest
   // (1 = last+1) so the nearest requester in rotation order wins.
   always_comb begin
      winner = 2'd0;
      idx    = 2'd0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = last + 2'(i);
         if (req[idx]) begin
            winner = idx;
         end
      end
      valid = |req;
   end

endmodule

// File: rtl/led_arbiter.sv
// Purpose : round-robin share of led_out among four requesters, fixed tick-timed hold per grant.
// Latency : grant registered on the edge req is seen; hold lasts HOLD_TICKS*TICK_DIV cycles, then >=1 dark cycle.
// Backpressure: none; requesters keep req high and wait, no preemption; dropping req aborts a hold.
//
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   req        - request level per requester
//   req_pat    - packed 4-bit patterns, requester i at [4i+3:4i]
//   gnt        - one-hot grant (registered)
//   done       - one-cycle pulse after a hold completes normally
//   busy       - high while a grant is held
//   led_out    - registered LED drive
module led_arbiter
   import led_ctrl_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int HOLD_TICKS = 250
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*LED_W-1:0] req_pat,
   output logic [N_REQ-1:0]       gnt,
   output logic                   done,
   output logic                   busy,
   output logic [LED_W-1:0]       led_out
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

   state_t             state_q, state_d;
   logic [1:0]         last_q, last_d;
   logic [PW-1:0]      pre_q, pre_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [LED_W-1:0]   led_q, led_d;

   logic [1:0]         pick_idx;
   logic               pick_vld;
   logic               tick;
   logic               req_live;

   rr_pick4 u_pick (
      .req    (req),
      .last   (last_q),
      .winner (pick_idx),
      .valid  (pick_vld)
   );

   // Prescaler only runs in HOLD and is held at 0 otherwise, so tick
   // can only assert while a grant is active.
   assign tick     = (state_q == ST_HOLD) && (pre_q == PRE_LAST);
   // gnt_q is one-hot, so this is the granted requester's req bit.
   assign req_live = |(gnt_q & req);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      pre_d   = pre_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      led_d   = led_q;

      case (state_q)
         ST_IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            led_d  = '0;
            pre_d  = '0;
            hold_d = '0;
            if (pick_vld) begin
               state_d         = ST_HOLD;
               last_d          = pick_idx;
               gnt_d[pick_idx] = 1'b1;
               busy_d          = 1'b1;
               led_d           = pat_slice(req_pat, pick_idx);
            end
         end

         ST_HOLD: begin
            // Completion is tested before abort so a req drop on the
            // terminal edge still reports done.
            if (tick && (hold_q == HOLD_LAST)) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               led_d   = '0;
               pre_d   = '0;
               hold_d  = '0;
            end else if (!req_live) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               led_d   = '0;
               pre_d   = '0;
               hold_d  = '0;
            end else if (tick) begin
               pre_d  = '0;
               hold_d = hold_q + 1'b1;
            end else begin
               pre_d  = pre_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            led_d   = '0;
            pre_d   = '0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= 2'd3;
         pre_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         pre_q   <= pre_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign led_out = led_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Purpose : scoreboard bench for led_arbiter with TICK_DIV=4, HOLD_TICKS=2 (8-cycle holds).
// Latency : expectations are queued per clock edge and checked 2 time units after that edge.
// Backpressure: n/a.
module tb_led_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_pat;
   logic [3:0]  gnt;
   logic        done;
   logic        busy;
   logic [3:0]  led_out;

   typedef struct packed {
      logic [3:0] g;
      logic [3:0] l;
      logic       b;
      logic       d;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   string phase;
   int    n_pass;
   int    n_check;
   int    n_fail;

   led_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .req_pat (req_pat),
      .gnt     (gnt),
      .done    (done),
      .busy    (busy),
      .led_out (led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: the DUT presents a fresh registered output after every edge;
   // compare it against the expectation queued for that edge.
   always @(posedge clk) begin
      exp_t  e;
      string t;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_check++;
         if (gnt === e.g && led_out === e.l && busy === e.b && done === e.d) begin
            n_pass++;
         end else begin
            n_fail++;
            $display("FAIL %s: gnt/led/busy/done got %b/%h/%b/%b want %b/%h/%b/%b",
                     t, gnt, led_out, busy, done, e.g, e.l, e.b, e.d);
         end
      end
   end

   // Queue n expected edges with the current inputs, stepping negedge to negedge.
   task automatic run(input int n, input logic [3:0] g, input logic [3:0] l,
                      input logic b, input logic d);
      exp_t e;
      e.g = g; e.l = l; e.b = b; e.d = d;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(e);
         tag_q.push_back(phase);
         @(negedge clk);
      end
   endtask

   initial begin
      n_pass  = 0;
      n_check = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      req     = 4'b0000;
      req_pat = 16'h0000;

      // Reset, then idle with no requests.
      phase = "reset";
      run(10, 4'b0000, 4'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      phase = "idle";
      run(20, 4'b0000, 4'h0, 1'b0, 1'b0);

      // Round-robin: all requesting, 8 lit + 1 dark per grant, order 0,1,2,3,0.
      phase   = "rr";
      req     = 4'b1111;
      req_pat = 16'h8421;
      run(8, 4'b0001, 4'h1, 1'b1, 1'b0);
      run(1, 4'b0000, 4'h0, 1'b0, 1'b1);
      run(8, 4'b0010, 4'h2, 1'b1, 1'b0);
      run(1, 4'b0000, 4'h0, 1'b0, 1'b1);
      run(8, 4'b0100, 4'h4, 1'b1, 1'b0);
      run(1, 4'b0000, 4'h0, 1'b0, 1'b1);
      run(8, 4'b1000, 4'h8, 1'b1, 1'b0);
      run(1, 4'b0000, 4'h0, 1'b0, 1'b1);
      run(8, 4'b0001, 4'h1, 1'b1, 1'b0);
      // Drop all requests on the terminal edge: completion still wins.
      phase = "simul";
      req   = 4'b0000;
      run(1, 4'b0000, 4'h0, 1'b0, 1'b1);
      run(2, 4'b0000, 4'h0, 1'b0, 1'b0);

      // Single grant to requester 1 (last=0), pattern A, req held through done.
      phase   = "single";
      req     = 4'b0010;
      req_pat = 16'h00A0;
      run(8, 4'b0010, 4'hA, 1'b1, 1'b0);
      run(1, 4'b0000, 4'h0, 1'b0, 1'b1);
      req = 4'b0000;
      run(2, 4'b0000, 4'h0, 1'b0, 1'b0);

      // Abort: grant 3, drop req[3] three cycles in with requester 0 waiting.
      phase   = "abort";
      req     = 4'b1000;
      req_pat = 16'hC007;
      run(3, 4'b1000, 4'hC, 1'b1, 1'b0);
      req = 4'b0001;
      run(1, 4'b0000, 4'h0, 1'b0, 1'b0);
      phase = "after_abort";
      run(3, 4'b0001, 4'h7, 1'b1, 1'b0);

      // Pattern change mid-hold must not reach led_out.
      phase   = "freeze";
      req_pat = 16'hC00E;
      run(2, 4'b0001, 4'h7, 1'b1, 1'b0);

      // Reset mid-hold.
      phase = "mid_rst";
      rst_n = 1'b0;
      run(2, 4'b0000, 4'h0, 1'b0, 1'b0);

      // After release requester 0 wins first again, then requester 1.
      phase = "post_rst";
      rst_n = 1'b1;
      req   = 4'b0011;
      run(8, 4'b0001, 4'hE, 1'b1, 1'b0);
      req_pat = 16'h005E;
      run(1, 4'b0000, 4'h0, 1'b0, 1'b1);
      run(8, 4'b0010, 4'h5, 1'b1, 1'b0);
      req = 4'b0000;
      run(1, 4'b0000, 4'h0, 1'b0, 1'b1);
      run(3, 4'b0000, 4'h0, 1'b0, 1'b0);

      // Let the monitor drain the last expectation.
      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_check++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
